// File: rtl/stream_mux_rr_if.sv
// Stream mux bundle: NCH producer channels in, one registered stream out.
// master drives the producer/consumer side, slave is the mux.
interface stream_mux_rr_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux: direct select (mode 0) or round-robin (mode 1).
// A single output slot gives one-cycle latency and full throughput.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_rr_if.slave  bus
);
    localparam int unsigned SELW = $clog2(NCH);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    slot_e              slot_q, slot_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SELW-1:0]    chan_q, chan_d;
    logic [SELW-1:0]    ptr_q,  ptr_d;

    logic [NCH-1:0]     grant_c;
    logic [NCH-1:0]     in_ready_c;
    logic               load_en_c;
    logic               xfer_c;
    logic               found_c;

    // Grant: direct select, or first valid channel after ptr, wrapping to the start
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        if (!bus.mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (32'(bus.sel) == i) grant_c[i] = bus.in_valid[i];
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!found_c && (i > 32'(ptr_q)) && bus.in_valid[i]) begin
                    grant_c[i] = 1'b1;
                    found_c    = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!found_c && (i <= 32'(ptr_q)) && bus.in_valid[i]) begin
                    grant_c[i] = 1'b1;
                    found_c    = 1'b1;
                end
            end
        end
    end

    assign load_en_c  = (slot_q == EMPTY) | bus.out_ready;
    assign in_ready_c = grant_c & {NCH{load_en_c & rst_n}};
    assign xfer_c     = |(bus.in_valid & in_ready_c);

    // Slot next state: load replaces (even while draining), drain alone empties
    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        chan_d = chan_q;
        ptr_d  = ptr_q;
        if (xfer_c) begin
            slot_d = FULL;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant_c[i]) begin
                    data_d = bus.in_data[i*WIDTH +: WIDTH];
                    chan_d = SELW'(i);
                    if (bus.mode) ptr_d = SELW'(i);
                end
            end
        end else if ((slot_q == FULL) && bus.out_ready) begin
            slot_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= EMPTY;
            data_q <= '0;
            chan_q <= '0;
            ptr_q  <= SELW'(NCH - 1);
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            chan_q <= chan_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (slot_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance.
module tb_stream_mux_rr;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(8), .NCH(4)) i4 ();
    stream_mux_rr_if #(.WIDTH(8), .NCH(3)) i3 ();

    stream_mux_rr #(.WIDTH(8), .NCH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    stream_mux_rr #(.WIDTH(8), .NCH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

    int rr_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_odd[4]  = '{1, 3, 1, 3};
    int rr_three[5] = '{0, 1, 2, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        i4.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        i4.in_valid  = 4'hF;
        i4.mode      = 1'b1;
        i4.sel       = 2'd0;
        i4.out_ready = 1'b1;
        i3.in_data   = {8'hC2, 8'hC1, 8'hC0};
        i3.in_valid  = 3'b000;
        i3.mode      = 1'b1;
        i3.sel       = 2'd0;
        i3.out_ready = 1'b1;
        tick();
        tick();

        // Reset state, in_ready forced low despite valid inputs
        chk("rst_valid", 32'(i4.out_valid), 32'd0);
        chk("rst_data",  32'(i4.out_data),  32'h00);
        chk("rst_chan",  32'(i4.out_chan),  32'd0);
        chk("rst_ready", 32'(i4.in_ready),  32'h0);

        // Mode 0 direct select sel=2
        rst_n   = 1'b1;
        i4.mode = 1'b0;
        i4.sel  = 2'd2;
        #1;
        chk("m0_ready", 32'(i4.in_ready), 32'h4);
        tick();
        chk("m0_data",  32'(i4.out_data),  32'hA2);
        chk("m0_chan",  32'(i4.out_chan),  32'd2);
        chk("m0_valid", 32'(i4.out_valid), 32'd1);

        // sel=3 with channel 3 idle: no grant, slot drains
        i4.sel      = 2'd3;
        i4.in_valid = 4'b0111;
        #1;
        chk("m0_idle_ready", 32'(i4.in_ready), 32'h0);
        tick();
        chk("m0_drain_valid", 32'(i4.out_valid), 32'd0);
        chk("m0_drain_data",  32'(i4.out_data),  32'hA2);
        chk("m0_drain_chan",  32'(i4.out_chan),  32'd2);

        // Round-robin, all valid
        i4.mode     = 1'b1;
        i4.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(i4.in_ready), 32'(1) << rr_all[k]);
            tick();
            chk("rr_chan",  32'(i4.out_chan),  32'(rr_all[k]));
            chk("rr_data",  32'(i4.out_data),  32'hA0 + 32'(rr_all[k]));
            chk("rr_valid", 32'(i4.out_valid), 32'd1);
        end

        // Round-robin, only channels 1 and 3
        i4.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            tick();
            chk("rr_odd_chan",  32'(i4.out_chan),  32'(rr_odd[k]));
            chk("rr_odd_valid", 32'(i4.out_valid), 32'd1);
        end

        // Backpressure: hold 0x55 from channel 1
        i4.in_data[15:8] = 8'h55;
        i4.in_valid      = 4'b0010;
        #1;
        tick();
        chk("bp_load_data", 32'(i4.out_data), 32'h55);
        chk("bp_load_chan", 32'(i4.out_chan), 32'd1);
        i4.out_ready     = 1'b0;
        i4.in_valid      = 4'hF;
        i4.in_data[15:8] = 8'hA1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(i4.in_ready), 32'h0);
            tick();
            chk("bp_data",  32'(i4.out_data),  32'h55);
            chk("bp_chan",  32'(i4.out_chan),  32'd1);
            chk("bp_valid", 32'(i4.out_valid), 32'd1);
        end
        i4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(i4.in_ready), 32'h4);
        tick();
        chk("bp_reload_chan",  32'(i4.out_chan),  32'd2);
        chk("bp_reload_data",  32'(i4.out_data),  32'hA2);
        chk("bp_reload_valid", 32'(i4.out_valid), 32'd1);

        // Mode switch with ptr=2: two direct transfers leave ptr alone
        i4.mode = 1'b0;
        i4.sel  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("sw_m0_ready", 32'(i4.in_ready), 32'h1);
            tick();
            chk("sw_m0_chan", 32'(i4.out_chan), 32'd0);
            chk("sw_m0_data", 32'(i4.out_data), 32'hA0);
        end
        i4.mode = 1'b1;
        #1;
        chk("sw_rr_ready", 32'(i4.in_ready), 32'h8);
        tick();
        chk("sw_rr_chan", 32'(i4.out_chan), 32'd3);
        chk("sw_rr_data", 32'(i4.out_data), 32'hA3);

        // Asynchronous reset mid-stream with a full slot
        chk("pre_rst_valid", 32'(i4.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(i4.out_valid), 32'd0);
        chk("arst_data",  32'(i4.out_data),  32'h00);
        chk("arst_chan",  32'(i4.out_chan),  32'd0);
        chk("arst_ready", 32'(i4.in_ready),  32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(i4.in_ready), 32'h1);
        tick();
        chk("post_rst_chan",  32'(i4.out_chan),  32'd0);
        chk("post_rst_data",  32'(i4.out_data),  32'hA0);
        chk("post_rst_valid", 32'(i4.out_valid), 32'd1);

        // NCH=3 round-robin wrap
        i3.in_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("n3_ready", 32'(i3.in_ready), 32'(1) << rr_three[k]);
            tick();
            chk("n3_chan", 32'(i3.out_chan), 32'(rr_three[k]));
            chk("n3_data", 32'(i3.out_data), 32'hC0 + 32'(rr_three[k]));
        end

        // NCH=3 direct select out of range, then in range
        i3.mode = 1'b0;
        i3.sel  = 2'd3;
        #1;
        chk("n3_sel3_ready", 32'(i3.in_ready), 32'h0);
        tick();
        chk("n3_sel3_valid", 32'(i3.out_valid), 32'd0);
        chk("n3_sel3_chan",  32'(i3.out_chan),  32'd1);
        i3.sel = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(i3.in_ready), 32'h4);
        tick();
        chk("n3_sel2_chan", 32'(i3.out_chan), 32'd2);
        chk("n3_sel2_data", 32'(i3.out_data), 32'hC2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
